cic_comp_fir: RTL



---
 rtl/cic_comp_pkg.sv | 12 +
 rtl/cic_comp_fir_round_sat.sv | 36 +++
 rtl/cic_comp_fir.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cic_comp_pkg.sv
// rtl/cic_comp_pkg.sv - shared FSM type and sizing helper for cic_comp_fir
package cic_comp_pkg;

  localparam int MAX_TAPS = 64;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, ROUND} state_t;

  function automatic int acc_width(input int inp_dw, input int coef_dw, input int num_taps);
    return inp_dw + coef_dw + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// rtl/cic_comp_fir_round_sat.sv - combinational round-half-up, arithmetic shift right and saturate
module round_sat #(
  parameter int IN_DW  = 54,
  parameter int OUT_DW = 32,
  parameter int FRAC   = 17
) (
  input  logic signed [IN_DW-1:0]  din,
  output logic signed [OUT_DW-1:0] dout
);

  localparam logic signed [IN_DW:0] MAXV = {{(IN_DW+2-OUT_DW){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [IN_DW:0] MINV = {{(IN_DW+2-OUT_DW){1'b1}}, {(OUT_DW-1){1'b0}}};

  logic signed [IN_DW:0] sum;
  logic signed [IN_DW:0] shr;

  // One guard bit so adding the half-LSB can never wrap the accumulator.
  if (FRAC > 0) begin : g_rnd
    assign sum = {din[IN_DW-1], din} + ((IN_DW+1)'(1) <<< (FRAC - 1));
  end else begin : g_nornd
    assign sum = {din[IN_DW-1], din};
  end

  assign shr = sum >>> FRAC;

  always_comb begin
    if (shr > MAXV) begin
      dout = {1'b0, {(OUT_DW-1){1'b1}}};
    end else if (shr < MINV) begin
      dout = {1'b1, {(OUT_DW-1){1'b0}}};
    end else begin
      dout = shr[OUT_DW-1:0];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - time-multiplexed CIC droop-compensation FIR; CIC_COMP_COEF_LOAD_EN adds a reloadable coefficient bank
// One multiplier walks the tap history per accepted sample; the sum is rounded and saturated.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int INP_DW    = 32,
  parameter int OUT_DW    = 32,
  parameter int COEF_DW   = 18,
  parameter int COEF_FRAC = 17,
  parameter int NUM_TAPS  = 16,
  parameter logic [NUM_TAPS*COEF_DW-1:0] COEFS = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [INP_DW-1:0] s_axis_in_tdata,
  input  logic                     s_axis_in_tvalid,
`ifdef CIC_COMP_COEF_LOAD_EN
  input  logic signed [COEF_DW-1:0] s_axis_coef_tdata,
  input  logic                      s_axis_coef_tvalid,
`endif
  output logic signed [OUT_DW-1:0] m_axis_out_tdata,
  output logic                     m_axis_out_tvalid,
  output logic                     overflow
);

  localparam int PW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PROD_W = INP_DW + COEF_DW;
  localparam int ACC_W  = acc_width(INP_DW, COEF_DW, NUM_TAPS);
  localparam logic [PW-1:0] LAST = PW'(NUM_TAPS - 1);

  if (NUM_TAPS < 1 || NUM_TAPS > MAX_TAPS) begin : g_bad_taps
    $error("cic_comp_fir: NUM_TAPS out of range");
  end

  state_t                    state_q, state_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, k_q, k_d, rd_addr;
  logic signed [INP_DW-1:0]  rd_q, rd_d;
  logic signed [COEF_DW-1:0] coef_q, coef_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      rd_vld_q, rd_vld_d, prod_vld_q, prod_vld_d;
  logic signed [OUT_DW-1:0]  rs_y, out_q, out_d;
  logic                      out_vld_q, out_vld_d, ovf_q, ovf_d, hist_we;
  logic signed [INP_DW-1:0]  hist_q [NUM_TAPS];
  logic signed [COEF_DW-1:0] coef_act [NUM_TAPS];

`ifdef CIC_COMP_COEF_LOAD_EN
  logic signed [COEF_DW-1:0] coef_act_q [NUM_TAPS];
  logic signed [COEF_DW-1:0] coef_shd_q [NUM_TAPS];
  logic [PW-1:0]             ci_q, ci_d;
  logic                      swap_pend_q, swap_pend_d, do_swap;

  // The active bank only changes in an idle cycle, so a MAC in flight never sees a mixed bank.
  always_comb begin
    do_swap     = swap_pend_q && (state_q == IDLE) && !s_axis_in_tvalid;
    ci_d        = ci_q;
    swap_pend_d = swap_pend_q && !do_swap;
    if (s_axis_coef_tvalid) begin
      if (ci_q == LAST) begin
        ci_d        = '0;
        swap_pend_d = 1'b1;
      end else begin
        ci_d = ci_q + PW'(1);
      end
    end
    for (int i = 0; i < NUM_TAPS; i++) coef_act[i] = coef_act_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ci_q        <= '0;
      swap_pend_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_act_q[i] <= COEFS[i*COEF_DW +: COEF_DW];
        coef_shd_q[i] <= COEFS[i*COEF_DW +: COEF_DW];
      end
    end else begin
      ci_q        <= ci_d;
      swap_pend_q <= swap_pend_d;
      if (s_axis_coef_tvalid) coef_shd_q[ci_q] <= s_axis_coef_tdata;
      if (do_swap) begin
        for (int i = 0; i < NUM_TAPS; i++) coef_act_q[i] <= coef_shd_q[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) coef_act[i] = COEFS[i*COEF_DW +: COEF_DW];
  end
`endif

  always_comb begin
    if (wr_ptr_q >= k_q) rd_addr = wr_ptr_q - k_q;
    else                 rd_addr = PW'(wr_ptr_q + PW'(NUM_TAPS) - k_q);
  end

  // Pipeline: history/coef read -> product register -> accumulate; DRAIN covers the two trailing stages.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    k_d        = k_q;
    acc_d      = acc_q;
    out_d      = out_q;
    out_vld_d  = 1'b0;
    ovf_d      = ovf_q;
    hist_we    = 1'b0;
    rd_d       = rd_q;
    coef_d     = coef_q;
    rd_vld_d   = (state_q == MAC);
    prod_vld_d = rd_vld_q;
    prod_d     = PROD_W'(rd_q) * PROD_W'(coef_q);
    if (prod_vld_q) acc_d = acc_q + ACC_W'(prod_q);
    if (s_axis_in_tvalid && (state_q != IDLE)) ovf_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (s_axis_in_tvalid) begin
          hist_we = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        rd_d   = hist_q[rd_addr];
        coef_d = coef_act[k_q];
        k_d    = k_q + PW'(1);
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (k_q == PW'(1)) begin
          k_d     = '0;
          state_d = ROUND;
        end else begin
          k_d = PW'(1);
        end
      end
      ROUND: begin
        out_d     = rs_y;
        out_vld_d = 1'b1;
        wr_ptr_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  round_sat #(.IN_DW(ACC_W), .OUT_DW(OUT_DW), .FRAC(COEF_FRAC)) u_round_sat (
    .din  (acc_q),
    .dout (rs_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      rd_q       <= '0;
      coef_q     <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      k_q        <= k_d;
      rd_q       <= rd_d;
      coef_q     <= coef_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      rd_vld_q   <= rd_vld_d;
      prod_vld_q <= prod_vld_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      ovf_q      <= ovf_d;
      if (hist_we) hist_q[wr_ptr_q] <= s_axis_in_tdata;
    end
  end

  assign m_axis_out_tdata  = out_q;
  assign m_axis_out_tvalid = out_vld_q;
  assign overflow          = ovf_q;

endmodule
